io_input_conditioner: RTL and testbench

Front-end for the memory-mapped input ports. It turns raw board switches and push-buttons into clean 32-bit words on `in_port0`/`in_port1` for the I/O input register stage. Each input is synchronised and debounced, and keys get sticky press-event flags that the CPU side clears with a per-key strobe. It sits between the board pins and the I/O input register stage, in the `clock` domain.

---
 rtl/io_input_conditioner_pkg.sv | 11 +
 rtl/io_input_conditioner_debounce_bit.sv | 43 ++++
 rtl/io_input_conditioner.sv | 74 +++++++
 tb/tb_io_input_conditioner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_input_conditioner_pkg.sv
// Shared constants for the input conditioner: in_port1 field positions,
// the default debounce window and the reset levels of each input kind.
package io_input_conditioner_pkg;

  localparam int   KEY_LVL_LSB      = 0;
  localparam int   KEY_EVT_LSB      = 4;
  localparam int   DB_LIMIT_DEFAULT = 50000;
  localparam logic KEY_RST_LVL      = 1'b1;  // keys are active-low, so released = 1
  localparam logic SW_RST_LVL       = 1'b0;

endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// One input bit: 2-FF synchroniser, stability counter and accepted level.
// accept flags the edge on which stable is about to take the synced value.
module io_input_conditioner_debounce_bit #(
  parameter logic RST_LVL  = 1'b0,
  parameter int   DB_LIMIT = 4,
  parameter int   DB_W     = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic stable,
  output logic accept
);

  localparam logic [DB_W-1:0] LIMIT_M1 = DB_W'(DB_LIMIT - 1);

  logic [1:0]      sync_q;
  logic [DB_W-1:0] cnt;
  logic            synced;

  assign synced = sync_q[1];
  assign accept = (synced != stable) && (cnt == LIMIT_M1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {2{RST_LVL}};
      cnt    <= '0;
      stable <= RST_LVL;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (synced == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= synced;
        cnt    <= '0;
      end else begin
        // accept fires at LIMIT_M1, so this never reaches the wrap point
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Board switch/button front-end: debounces every raw input and presents
// switch levels, key levels and sticky key-press events as 32-bit words.
module io_input_conditioner
  import io_input_conditioner_pkg::*;
#(
  parameter int NSW      = 10,
  parameter int NKEY     = 3,
  parameter int DB_LIMIT = DB_LIMIT_DEFAULT,
  parameter int DB_W     = 16
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [NSW-1:0]  sw_raw,
  input  logic [NKEY-1:0] key_raw,
  input  logic [NKEY-1:0] evt_clr,
  output logic [31:0]     in_port0,
  output logic [31:0]     in_port1
);

  logic [NSW-1:0]  sw_stable;
  logic [NSW-1:0]  unused_sw_accept;
  logic [NKEY-1:0] key_stable;
  logic [NKEY-1:0] key_accept;
  logic [NKEY-1:0] evt_set;
  logic [NKEY-1:0] evt;

  for (genvar i = 0; i < NSW; i++) begin : g_sw
    io_input_conditioner_debounce_bit #(
      .RST_LVL (SW_RST_LVL),
      .DB_LIMIT(DB_LIMIT),
      .DB_W    (DB_W)
    ) u_db (
      .clock (clock),
      .resetn(resetn),
      .raw   (sw_raw[i]),
      .stable(sw_stable[i]),
      .accept(unused_sw_accept[i])
    );
  end

  for (genvar i = 0; i < NKEY; i++) begin : g_key
    io_input_conditioner_debounce_bit #(
      .RST_LVL (KEY_RST_LVL),
      .DB_LIMIT(DB_LIMIT),
      .DB_W    (DB_W)
    ) u_db (
      .clock (clock),
      .resetn(resetn),
      .raw   (key_raw[i]),
      .stable(key_stable[i]),
      .accept(key_accept[i])
    );
  end

  // An accepted change while currently released is a debounced press.
  assign evt_set = key_accept & key_stable;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      evt <= '0;
    end else begin
      evt <= (evt & ~evt_clr) | evt_set;
    end
  end

  always_comb begin
    in_port0                          = '0;
    in_port0[NSW-1:0]                 = sw_stable;
    in_port1                          = '0;
    in_port1[KEY_LVL_LSB +: NKEY]     = ~key_stable;
    in_port1[KEY_EVT_LSB +: NKEY]     = evt;
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with DB_LIMIT=4: vector table, directed
// corner sequences and random stimulus against a window-based model.
module tb_io_input_conditioner;

  localparam int NSW  = 10;
  localparam int NKEY = 3;
  localparam int DBL  = 4;

  logic            clock;
  logic            resetn;
  logic [NSW-1:0]  sw_raw;
  logic [NKEY-1:0] key_raw;
  logic [NKEY-1:0] evt_clr;
  logic [31:0]     in_port0;
  logic [31:0]     in_port1;

  int total = 0;
  int bad   = 0;

  io_input_conditioner #(
    .NSW(NSW), .NKEY(NKEY), .DB_LIMIT(DBL), .DB_W(16)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .sw_raw  (sw_raw),
    .key_raw (key_raw),
    .evt_clr (evt_clr),
    .in_port0(in_port0),
    .in_port1(in_port1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: a bit's accepted level becomes v once the last DBL synchronised
  // samples (raw samples two edges old) all equal v.
  logic [NSW-1:0]  sw_hist[$];
  logic [NKEY-1:0] key_hist[$];
  logic [NSW-1:0]  m_sw;
  logic [NKEY-1:0] m_key;
  logic [NKEY-1:0] m_evt;

  task automatic model_reset();
    sw_hist.delete();
    key_hist.delete();
    for (int i = 0; i < DBL + 2; i++) begin
      sw_hist.push_back('0);
      key_hist.push_back('1);
    end
    m_sw  = '0;
    m_key = '1;
    m_evt = '0;
  endtask

  task automatic model_edge();
    logic [NSW-1:0]  a_sw, o_sw, n_sw;
    logic [NKEY-1:0] a_key, o_key, n_key;
    sw_hist.push_back(sw_raw);
    void'(sw_hist.pop_front());
    key_hist.push_back(key_raw);
    void'(key_hist.pop_front());
    a_sw = '1; o_sw = '0; a_key = '1; o_key = '0;
    for (int i = 0; i < DBL; i++) begin
      a_sw  &= sw_hist[i];
      o_sw  |= sw_hist[i];
      a_key &= key_hist[i];
      o_key |= key_hist[i];
    end
    n_sw  = (m_sw & o_sw) | a_sw;
    n_key = (m_key & o_key) | a_key;
    m_evt = (m_evt & ~evt_clr) | (m_key & ~n_key);
    m_sw  = n_sw;
    m_key = n_key;
  endtask

  function automatic logic [31:0] exp_port0();
    logic [31:0] r;
    r = '0;
    r[NSW-1:0] = m_sw;
    return r;
  endfunction

  function automatic logic [31:0] exp_port1();
    logic [31:0] r;
    r = '0;
    r[NKEY-1:0] = ~m_key;
    r[4 +: NKEY] = m_evt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model advances on the edge, both ports compared at negedge.
  task automatic cycle();
    @(posedge clock);
    if (resetn) model_edge();
    @(negedge clock);
    chk("model_port0", in_port0, exp_port0());
    chk("model_port1", in_port1, exp_port1());
  endtask

  typedef struct {
    logic [NSW-1:0]  sw;
    logic [NKEY-1:0] key;
    logic [NKEY-1:0] clr;
    int              ncyc;
    logic [31:0]     e0;
    logic [31:0]     e1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{10'h3FF, 3'b000, 3'b111, 1, 32'h3FF, 32'h07};
    vecs[1] = '{10'h000, 3'b111, 3'b000, 8, 32'h000, 32'h00};
    vecs[2] = '{10'h155, 3'b110, 3'b000, 8, 32'h155, 32'h11};
    vecs[3] = '{10'h2AA, 3'b111, 3'b001, 8, 32'h2AA, 32'h00};
    vecs[4] = '{10'h000, 3'b011, 3'b000, 8, 32'h000, 32'h44};
    vecs[5] = '{10'h000, 3'b111, 3'b000, 8, 32'h000, 32'h40};
    vecs[6] = '{10'h000, 3'b111, 3'b100, 1, 32'h000, 32'h00};

    // Reset with all inputs active
    resetn = 1'b1; sw_raw = 10'h3FF; key_raw = 3'b000; evt_clr = '0;
    #1 resetn = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("reset_port0", in_port0, 32'h0);
      chk("reset_port1", in_port1, 32'h0);
    end
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk($sformatf("rel_port0_e%0d", k), in_port0, (k == 6) ? 32'h3FF : 32'h0);
      chk($sformatf("rel_port1_e%0d", k), in_port1, (k == 6) ? 32'h77 : 32'h0);
    end

    // Vector table
    for (int v = 0; v < 7; v++) begin
      sw_raw = vecs[v].sw; key_raw = vecs[v].key; evt_clr = vecs[v].clr;
      cycle();
      evt_clr = '0;
      for (int c = 1; c < vecs[v].ncyc; c++) cycle();
      chk($sformatf("vec%0d_port0", v), in_port0, vecs[v].e0);
      chk($sformatf("vec%0d_port1", v), in_port1, vecs[v].e1);
    end

    // Switch latency
    sw_raw[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk($sformatf("swlat_e%0d", k), in_port0, (k == 6) ? 32'h8 : 32'h0);
    end

    // Glitch rejection, then a held press
    key_raw[1] = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    key_raw[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("glitch_port1", in_port1, 32'h0);
    end
    key_raw[1] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk($sformatf("press1_e%0d", k), in_port1, (k == 6) ? 32'h22 : 32'h0);
    end

    // Clear and re-arm
    evt_clr = 3'b010;
    cycle();
    evt_clr = '0;
    chk("clr_port1", in_port1, 32'h02);
    key_raw[1] = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    chk("release1_port1", in_port1, 32'h0);
    key_raw[1] = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    chk("repress1_port1", in_port1, 32'h22);

    // Set beats clear on the same edge
    key_raw[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk("press0_wait", in_port1, 32'h22);
    end
    evt_clr = 3'b001;
    cycle();
    evt_clr = '0;
    chk("set_beats_clr", in_port1, 32'h33);
    cycle();
    chk("set_beats_clr_hold", in_port1, 32'h33);

    // Reset mid-debounce
    sw_raw[0] = 1'b1;
    cycle();
    cycle();
    resetn = 1'b0;
    model_reset();
    #1;
    chk("midrst_port0", in_port0, 32'h0);
    chk("midrst_port1", in_port1, 32'h0);
    cycle();
    cycle();
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      chk($sformatf("midrst_rel0_e%0d", k), in_port0, (k == 6) ? 32'h9 : 32'h0);
      chk($sformatf("midrst_rel1_e%0d", k), in_port1, (k == 6) ? 32'h33 : 32'h0);
    end

    // Random stimulus against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        int idx;
        idx = int'($urandom_range(0, NSW - 1));
        sw_raw[idx] = ~sw_raw[idx];
      end
      if ($urandom_range(0, 4) == 0) begin
        int idx;
        idx = int'($urandom_range(0, NKEY - 1));
        key_raw[idx] = ~key_raw[idx];
      end
      evt_clr = ($urandom_range(0, 7) == 0) ? NKEY'($urandom_range(0, 7)) : '0;
      if (n == 300) begin
        resetn = 1'b0;
        model_reset();
        cycle();
        resetn = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
